// File: rtl/multdiv_sequencer.sv
// Issue controller between execute and the multdiv unit: one op in flight,
// registered operands, start pulse, guarded wait, held writeback.
// Ports: clock/rst_n, req_* (execute side), md_* (multdiv side),
//   wb_* (regfile side), busy/pending_* (hazards), flush, timeout_err.
module multdiv_sequencer #(
  parameter int          TIMEOUT_CYCLES = 40,
  parameter int          RDY_BLANK      = 1,
  parameter logic [4:0]  STATUS_REG     = 5'd30,
  parameter logic [31:0] MULT_EXC_CODE  = 32'd4,
  parameter logic [31:0] DIV_EXC_CODE   = 32'd5
) (
  input  logic        clock,
  input  logic        rst_n,
  input  logic        req_valid,
  input  logic        req_op,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  input  logic [4:0]  req_rd,
  output logic        req_ready,
  input  logic        flush,
  output logic [31:0] md_operandA,
  output logic [31:0] md_operandB,
  output logic        md_ctrl_MULT,
  output logic        md_ctrl_DIV,
  input  logic [31:0] md_result,
  input  logic        md_exception,
  input  logic        md_resultRDY,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        wb_exception,
  input  logic        wb_ack,
  output logic        busy,
  output logic        pending_valid,
  output logic [4:0]  pending_rd,
  output logic        timeout_err
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] T_LAST  = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0] T_BLANK = TW'(RDY_BLANK);

  typedef enum logic [1:0] {
    IDLE,
    START,
    WAIT,
    WB
  } state_t;

  state_t          state;
  logic            op_q;
  logic [4:0]      rd_q;
  logic [TW-1:0]   timer;
  logic            accept;
  logic            rdy_ok;

  // A WB slot being acked can take the next request without an IDLE gap.
  assign req_ready = ~flush &
                     ((state == IDLE) |
                      ((state == WB) & wb_ack));
  assign accept    = req_valid & req_ready;

  // Ready inside the blanking window may be left over from a flushed op.
  assign rdy_ok = (state == WAIT) & ~flush &
                  md_resultRDY & (timer >= T_BLANK);

  assign timeout_err = (state == WAIT) & ~flush &
                       ~rdy_ok & (timer == T_LAST);

  assign busy          = (state != IDLE);
  assign pending_valid = busy;
  assign pending_rd    = (state == WB)   ? wb_rd :
                         (state == IDLE) ? 5'd0  : rd_q;

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      op_q         <= 1'b0;
      rd_q         <= 5'd0;
      timer        <= '0;
      md_operandA  <= 32'd0;
      md_operandB  <= 32'd0;
      md_ctrl_MULT <= 1'b0;
      md_ctrl_DIV  <= 1'b0;
      wb_valid     <= 1'b0;
      wb_rd        <= 5'd0;
      wb_data      <= 32'd0;
      wb_exception <= 1'b0;
    end else begin
      md_ctrl_MULT <= 1'b0;
      md_ctrl_DIV  <= 1'b0;
      if (accept) begin
        op_q         <= req_op;
        rd_q         <= req_rd;
        md_operandA  <= req_a;
        md_operandB  <= req_b;
        md_ctrl_MULT <= ~req_op;
        md_ctrl_DIV  <= req_op;
        wb_valid     <= 1'b0;
        state        <= START;
      end else begin
        case (state)
          IDLE: state <= IDLE;
          START: begin
            timer <= '0;
            state <= flush ? IDLE : WAIT;
          end
          WAIT: begin
            if (flush) begin
              state <= IDLE;
            end else if (rdy_ok) begin
              if (md_exception) begin
                wb_rd        <= STATUS_REG;
                wb_data      <= op_q ? DIV_EXC_CODE
                                     : MULT_EXC_CODE;
                wb_exception <= 1'b1;
                wb_valid     <= 1'b1;
                state        <= WB;
              end else if (rd_q == 5'd0) begin
                state <= IDLE;
              end else begin
                wb_rd        <= rd_q;
                wb_data      <= md_result;
                wb_exception <= 1'b0;
                wb_valid     <= 1'b1;
                state        <= WB;
              end
            end else if (timer == T_LAST) begin
              state <= IDLE;
            end else begin
              timer <= timer + 1'b1;
            end
          end
          WB: begin
            if (flush | wb_ack) begin
              wb_valid <= 1'b0;
              state    <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_multdiv_sequencer.sv
// Directed bench for multdiv_sequencer; the bench itself plays the
// multdiv by driving md_resultRDY/md_result/md_exception.
module tb_multdiv_sequencer;

  logic        clock = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_op;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic [4:0]  req_rd;
  logic        req_ready;
  logic        flush;
  logic [31:0] md_operandA;
  logic [31:0] md_operandB;
  logic        md_ctrl_MULT;
  logic        md_ctrl_DIV;
  logic [31:0] md_result;
  logic        md_exception;
  logic        md_resultRDY;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        wb_exception;
  logic        wb_ack;
  logic        busy;
  logic        pending_valid;
  logic [4:0]  pending_rd;
  logic        timeout_err;

  int checks = 0;
  int errors = 0;
  int n_mult = 0;
  int n_div  = 0;
  int n_both = 0;

  always #5 clock = ~clock;

  multdiv_sequencer dut (
    .clock(clock), .rst_n(rst_n),
    .req_valid(req_valid), .req_op(req_op),
    .req_a(req_a), .req_b(req_b), .req_rd(req_rd),
    .req_ready(req_ready), .flush(flush),
    .md_operandA(md_operandA), .md_operandB(md_operandB),
    .md_ctrl_MULT(md_ctrl_MULT), .md_ctrl_DIV(md_ctrl_DIV),
    .md_result(md_result), .md_exception(md_exception),
    .md_resultRDY(md_resultRDY),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .wb_exception(wb_exception), .wb_ack(wb_ack),
    .busy(busy), .pending_valid(pending_valid),
    .pending_rd(pending_rd), .timeout_err(timeout_err)
  );

  always @(negedge clock) begin
    if (md_ctrl_MULT) n_mult <= n_mult + 1;
    if (md_ctrl_DIV)  n_div  <= n_div + 1;
    if (md_ctrl_MULT && md_ctrl_DIV) n_both <= n_both + 1;
  end

  // Called at a negedge while IDLE; returns at the START-cycle negedge.
  task automatic issue(input logic op, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] rd);
    req_valid = 1'b1; req_op = op;
    req_a = a; req_b = b; req_rd = rd;
    @(negedge clock);
    req_valid = 1'b0;
    checks++;
    if (md_ctrl_MULT !== ~op || md_ctrl_DIV !== op) begin
      errors++;
      $display("FAIL start_pulse: mult=%b div=%b exp op=%b",
               md_ctrl_MULT, md_ctrl_DIV, op);
    end
    checks++;
    if (md_operandA !== a || md_operandB !== b) begin
      errors++;
      $display("FAIL operands: %h %h exp %h %h",
               md_operandA, md_operandB, a, b);
    end
  endtask

  // Called at the START negedge; returns one cycle after qualifying RDY.
  task automatic respond(input logic [31:0] res, input logic exc);
    @(negedge clock);
    md_resultRDY = 1'b0;
    @(negedge clock);
    md_resultRDY = 1'b1; md_result = res; md_exception = exc;
    @(negedge clock);
    md_resultRDY = 1'b0; md_exception = 1'b0;
  endtask

  task automatic ack_wb();
    wb_ack = 1'b1;
    @(negedge clock);
    wb_ack = 1'b0;
    checks++;
    if (wb_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL ack: wb_valid=%b busy=%b exp 0 0",
               wb_valid, busy);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_valid = 1'b0; req_op = 1'b0;
    req_a = 32'd0; req_b = 32'd0; req_rd = 5'd0;
    flush = 1'b0; md_result = 32'd0; md_exception = 1'b0;
    md_resultRDY = 1'b0; wb_ack = 1'b0;
    repeat (3) @(negedge clock);
    checks++;
    if (busy !== 1'b0 || wb_valid !== 1'b0 ||
        md_operandA !== 32'd0 || pending_valid !== 1'b0 ||
        md_ctrl_MULT !== 1'b0 || timeout_err !== 1'b0) begin
      errors++;
      $display("FAIL reset: busy=%b wbv=%b opA=%h pv=%b",
               busy, wb_valid, md_operandA, pending_valid);
    end
    rst_n = 1'b1;
    @(negedge clock);
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_after_reset: %b exp 1", req_ready);
    end
  endtask

  task automatic test_mult();
    int m0;
    m0 = n_mult;
    issue(1'b0, 32'd7, -32'sd3, 5'd5);
    @(negedge clock);
    // stale ready during the blanking cycle must be ignored
    md_resultRDY = 1'b1; md_result = 32'hDEAD;
    @(negedge clock);
    checks++;
    if (wb_valid !== 1'b0 || busy !== 1'b1 || pending_rd !== 5'd5) begin
      errors++;
      $display("FAIL blank: wbv=%b busy=%b prd=%0d exp 0 1 5",
               wb_valid, busy, pending_rd);
    end
    md_result = 32'hFFFFFFEB;
    @(negedge clock);
    md_resultRDY = 1'b0;
    checks++;
    if (wb_valid !== 1'b1 || wb_rd !== 5'd5 ||
        wb_data !== 32'hFFFFFFEB || wb_exception !== 1'b0) begin
      errors++;
      $display("FAIL mult_wb: v=%b rd=%0d d=%h e=%b exp 1 5 ffffffeb 0",
               wb_valid, wb_rd, wb_data, wb_exception);
    end
    @(negedge clock);
    checks++;
    if (wb_valid !== 1'b1 || wb_data !== 32'hFFFFFFEB) begin
      errors++;
      $display("FAIL mult_hold: v=%b d=%h", wb_valid, wb_data);
    end
    ack_wb();
    checks++;
    if (n_mult - m0 !== 1) begin
      errors++;
      $display("FAIL mult_pulses: %0d exp 1", n_mult - m0);
    end
  endtask

  task automatic test_div_exception();
    issue(1'b1, 32'd100, 32'd0, 5'd9);
    respond(32'h0, 1'b1);
    checks++;
    if (wb_valid !== 1'b1 || wb_rd !== 5'd30 || wb_data !== 32'd5 ||
        wb_exception !== 1'b1 || pending_rd !== 5'd30) begin
      errors++;
      $display("FAIL div_exc: v=%b rd=%0d d=%0d e=%b prd=%0d",
               wb_valid, wb_rd, wb_data, wb_exception, pending_rd);
    end
    ack_wb();
  endtask

  task automatic test_back_to_back();
    issue(1'b1, 32'd100, 32'd7, 5'd3);
    respond(32'd14, 1'b0);
    checks++;
    if (wb_valid !== 1'b1 || wb_data !== 32'd14 || wb_rd !== 5'd3) begin
      errors++;
      $display("FAIL b2b_div: v=%b d=%0d rd=%0d exp 1 14 3",
               wb_valid, wb_data, wb_rd);
    end
    wb_ack = 1'b1;
    req_valid = 1'b1; req_op = 1'b0;
    req_a = 32'd6; req_b = 32'd2; req_rd = 5'd8;
    @(negedge clock);
    wb_ack = 1'b0; req_valid = 1'b0;
    checks++;
    if (md_ctrl_MULT !== 1'b1 || busy !== 1'b1 ||
        wb_valid !== 1'b0 || md_operandA !== 32'd6) begin
      errors++;
      $display("FAIL b2b_start: mult=%b busy=%b wbv=%b opA=%0d",
               md_ctrl_MULT, busy, wb_valid, md_operandA);
    end
    respond(32'd12, 1'b0);
    checks++;
    if (wb_valid !== 1'b1 || wb_data !== 32'd12 || wb_rd !== 5'd8) begin
      errors++;
      $display("FAIL b2b_mult: v=%b d=%0d rd=%0d exp 1 12 8",
               wb_valid, wb_data, wb_rd);
    end
    ack_wb();
  endtask

  task automatic test_flush();
    int seen;
    seen = 0;
    issue(1'b0, 32'd9, 32'd9, 5'd7);
    repeat (3) @(negedge clock);
    flush = 1'b1;
    checks++;
    if (req_ready !== 1'b0) begin
      errors++;
      $display("FAIL flush_ready: %b exp 0", req_ready);
    end
    @(negedge clock);
    flush = 1'b0;
    checks++;
    if (busy !== 1'b0 || pending_valid !== 1'b0) begin
      errors++;
      $display("FAIL flush_idle: busy=%b pv=%b exp 0 0",
               busy, pending_valid);
    end
    @(negedge clock);
    md_resultRDY = 1'b1; md_result = 32'd81;
    @(negedge clock);
    md_resultRDY = 1'b0;
    if (wb_valid) seen++;
    @(negedge clock);
    if (wb_valid) seen++;
    checks++;
    if (seen !== 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL flush_discard: wb_valid seen %0d busy=%b exp 0 0",
               seen, busy);
    end
    issue(1'b0, 32'd6, 32'd6, 5'd4);
    respond(32'd36, 1'b0);
    checks++;
    if (wb_valid !== 1'b1 || wb_data !== 32'd36 || wb_rd !== 5'd4) begin
      errors++;
      $display("FAIL flush_next: v=%b d=%0d rd=%0d exp 1 36 4",
               wb_valid, wb_data, wb_rd);
    end
    ack_wb();
  endtask

  task automatic test_timeout();
    int early;
    int d0;
    int m0;
    early = 0;
    d0 = n_div;
    m0 = n_mult;
    issue(1'b1, 32'd1, 32'd1, 5'd6);
    // a request while busy must be dropped, not queued
    req_valid = 1'b1; req_op = 1'b0; req_rd = 5'd20;
    for (int i = 1; i < 40; i++) begin
      @(negedge clock);
      if (i == 10) req_valid = 1'b0;
      if (timeout_err) early++;
    end
    checks++;
    if (early !== 0) begin
      errors++;
      $display("FAIL timeout_early: %0d pulses exp 0", early);
    end
    @(negedge clock);
    checks++;
    if (timeout_err !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL timeout_pulse: te=%b busy=%b exp 1 1",
               timeout_err, busy);
    end
    @(negedge clock);
    checks++;
    if (timeout_err !== 1'b0 || busy !== 1'b0 ||
        req_ready !== 1'b1 || wb_valid !== 1'b0) begin
      errors++;
      $display("FAIL timeout_idle: te=%b busy=%b rdy=%b wbv=%b",
               timeout_err, busy, req_ready, wb_valid);
    end
    checks++;
    if (n_div - d0 !== 1 || n_mult - m0 !== 0) begin
      errors++;
      $display("FAIL timeout_pulses: div=%0d mult=%0d exp 1 0",
               n_div - d0, n_mult - m0);
    end
  endtask

  task automatic test_rd_zero();
    issue(1'b0, 32'd3, 32'd3, 5'd0);
    @(negedge clock);
    @(negedge clock);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL rd0_busy: %b exp 1", busy);
    end
    md_resultRDY = 1'b1; md_result = 32'd9;
    @(negedge clock);
    md_resultRDY = 1'b0;
    checks++;
    if (wb_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL rd0_drop: wbv=%b busy=%b exp 0 0",
               wb_valid, busy);
    end
  endtask

  task automatic test_async_reset();
    issue(1'b0, 32'd2, 32'd2, 5'd11);
    @(negedge clock);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || md_operandA !== 32'd0 ||
        pending_valid !== 1'b0 || pending_rd !== 5'd0 ||
        wb_valid !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: busy=%b opA=%h pv=%b prd=%0d",
               busy, md_operandA, pending_valid, pending_rd);
    end
    @(negedge clock);
    rst_n = 1'b1;
    @(negedge clock);
    checks++;
    if (req_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL post_reset: rdy=%b busy=%b exp 1 0",
               req_ready, busy);
    end
  endtask

  initial begin
    test_reset();
    test_mult();
    test_div_exception();
    test_back_to_back();
    test_flush();
    test_timeout();
    test_rd_zero();
    test_async_reset();
    checks++;
    if (n_both !== 0) begin
      errors++;
      $display("FAIL dual_pulse: %0d cycles both high", n_both);
    end
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
